// File: rtl/rom_stream_reader_if.sv
// Output stream bundle for rom_stream_reader.
// The producer uses the master modport and the consumer uses the slave modport.
interface rom_stream_reader_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/rom_stream_reader.sv
// Sequences reads from a 1-cycle-latency synchronous ROM and buffers the words
// in a 2-entry FIFO that feeds a valid/ready stream with a last-beat flag.
module rom_stream_reader #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 10,
    parameter int LEN_WIDTH     = 11
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]     length,
    output logic                     busy,
    output logic                     done,
    output logic                     rom_en,
    output logic [ADDRESS_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0]    rom_data,
    rom_stream_reader_if.master      out_if
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] FIN   = 2'd3;

    logic [1:0]               state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]     remain_q, remain_d;
    logic                     inflight_q, inflight_d;
    logic                     inflight_last_q, inflight_last_d;
    logic [1:0]               count_q, count_d;
    logic [DATA_WIDTH-1:0]    head_data_q, head_data_d;
    logic                     head_last_q, head_last_d;
    logic [DATA_WIDTH-1:0]    tail_data_q, tail_data_d;
    logic                     tail_last_q, tail_last_d;

    logic       pop;
    logic       issue;
    logic [2:0] occupancy;

    always_comb begin
        pop       = (count_q != 2'd0) && out_if.out_ready;
        // Slots already committed once this cycle's pop and pending write settle.
        occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
        issue     = (state_q == RUN) && (occupancy < 3'd2);

        state_d         = state_q;
        addr_d          = addr_q;
        remain_d        = remain_q;
        inflight_d      = issue;
        inflight_last_d = issue && (remain_q == LEN_WIDTH'(1));
        count_d         = count_q;
        head_data_d     = head_data_q;
        head_last_d     = head_last_q;
        tail_data_d     = tail_data_q;
        tail_last_d     = tail_last_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (length == '0) begin
                        state_d = FIN;
                    end else begin
                        state_d  = RUN;
                        addr_d   = base_addr;
                        remain_d = length;
                    end
                end
            end
            RUN: begin
                if (issue && (remain_q == LEN_WIDTH'(1))) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && head_last_q) begin
                    state_d = FIN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (issue) begin
            addr_d   = addr_q + ADDRESS_WIDTH'(1);
            remain_d = remain_q - LEN_WIDTH'(1);
        end

        case ({inflight_q, pop})
            2'b10: begin
                count_d = count_q + 2'd1;
                if (count_q == 2'd0) begin
                    head_data_d = rom_data;
                    head_last_d = inflight_last_q;
                end else begin
                    tail_data_d = rom_data;
                    tail_last_d = inflight_last_q;
                end
            end
            2'b01: begin
                count_d     = count_q - 2'd1;
                head_data_d = tail_data_q;
                head_last_d = tail_last_q;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    head_data_d = rom_data;
                    head_last_d = inflight_last_q;
                end else begin
                    head_data_d = tail_data_q;
                    head_last_d = tail_last_q;
                    tail_data_d = rom_data;
                    tail_last_d = inflight_last_q;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            remain_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            count_q         <= '0;
            head_data_q     <= '0;
            head_last_q     <= 1'b0;
            tail_data_q     <= '0;
            tail_last_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            remain_q        <= remain_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            count_q         <= count_d;
            head_data_q     <= head_data_d;
            head_last_q     <= head_last_d;
            tail_data_q     <= tail_data_d;
            tail_last_q     <= tail_last_d;
        end
    end

    assign busy             = (state_q == RUN) || (state_q == DRAIN);
    assign done             = (state_q == FIN);
    assign rom_en           = issue;
    assign rom_addr         = addr_q;
    assign out_if.out_valid = (count_q != 2'd0);
    assign out_if.out_data  = head_data_q;
    assign out_if.out_last  = (count_q != 2'd0) && head_last_q;
endmodule

// File: tb/tb_rom_stream_reader.sv
// Self-checking bench for rom_stream_reader: a behavioural ROM, a beat/address
// scoreboard filled at start time, and per-scenario tasks.
module tb_rom_stream_reader;
    localparam int DW = 8;
    localparam int AW = 10;
    localparam int LW = 11;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [LW-1:0] length;
    logic          busy;
    logic          done;
    logic          rom_en;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;

    rom_stream_reader_if #(.DATA_WIDTH(DW)) sif ();

    rom_stream_reader #(
        .DATA_WIDTH   (DW),
        .ADDRESS_WIDTH(AW),
        .LEN_WIDTH    (LW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .base_addr(base_addr),
        .length   (length),
        .busy     (busy),
        .done     (done),
        .rom_en   (rom_en),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .out_if   (sif)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always @(posedge clk) begin
        if (rom_en) rom_data <= mem[rom_addr];
    end

    function automatic logic [DW-1:0] rom_word(input int a);
        return DW'((a * 37 + 11) ^ (a >> 3));
    endfunction

    int            vectors = 0;
    int            miscompares = 0;
    int            beats_seen = 0;
    int            outstanding = 0;
    int            pop_now;
    logic [DW:0]   exp_q[$];
    logic [AW-1:0] addr_q[$];
    logic [DW:0]   exp_beat;
    logic [AW-1:0] exp_addr;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;

    always @(negedge clk) begin
        if (rst) begin
            outstanding = 0;
            prev_stall  = 1'b0;
        end else begin
            pop_now = (sif.out_valid && sif.out_ready) ? 1 : 0;
            if (pop_now == 1) begin
                vectors++;
                beats_seen++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_beat: got data %0h last %0b, expected no beat",
                             sif.out_data, sif.out_last);
                end else begin
                    exp_beat = exp_q.pop_front();
                    if ({sif.out_last, sif.out_data} !== exp_beat) begin
                        miscompares++;
                        $display("FAIL beat: got last/data %0h, expected %0h",
                                 {sif.out_last, sif.out_data}, exp_beat);
                    end
                end
            end
            if (prev_stall) begin
                vectors++;
                if (!sif.out_valid || sif.out_data !== prev_data || sif.out_last !== prev_last) begin
                    miscompares++;
                    $display("FAIL stall_stable: got v/d/l %0b/%0h/%0b, expected 1/%0h/%0b",
                             sif.out_valid, sif.out_data, sif.out_last, prev_data, prev_last);
                end
            end
            if (rom_en) begin
                vectors++;
                if (outstanding - pop_now >= 2) begin
                    miscompares++;
                    $display("FAIL rom_en_space: got read with %0d slots committed, expected < 2",
                             outstanding - pop_now);
                end
                vectors++;
                if (addr_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_read: got rom_addr %0h, expected no read", rom_addr);
                end else begin
                    exp_addr = addr_q.pop_front();
                    if (rom_addr !== exp_addr) begin
                        miscompares++;
                        $display("FAIL rom_addr: got %0h, expected %0h", rom_addr, exp_addr);
                    end
                end
            end
            outstanding = outstanding + (rom_en ? 1 : 0) - pop_now;
            prev_stall  = sif.out_valid && !sif.out_ready;
            prev_data   = sif.out_data;
            prev_last   = sif.out_last;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [AW-1:0] b, input int n);
        start     = 1'b1;
        base_addr = b;
        length    = LW'(n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({(i == n - 1) ? 1'b1 : 1'b0, rom_word((int'(b) + i) % (1 << AW))});
            addr_q.push_back(AW'(int'(b) + i));
        end
        cyc();
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound, output int n);
        n = 0;
        while (!done && n < bound) begin
            cyc();
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; sif.out_ready = 1'b0;
        cyc(); cyc();
        vectors++;
        if ({busy, done, rom_en, rom_addr, sif.out_valid, sif.out_data, sif.out_last} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %0h, expected 0",
                     {busy, done, rom_en, rom_addr, sif.out_valid, sif.out_data, sif.out_last});
        end
        rst = 1'b0;
        cyc();
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || sif.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_idle: got busy/done/valid %0b%0b%0b, expected 000",
                     busy, done, sif.out_valid);
        end
    endtask

    task automatic test_basic();
        int n;
        sif.out_ready = 1'b1;
        do_start(10'h010, 4);
        vectors++;
        if (rom_en !== 1'b1 || rom_addr !== 10'h010 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_cycle1: got en/addr/busy %0b/%0h/%0b, expected 1/10/1",
                     rom_en, rom_addr, busy);
        end
        cyc();
        vectors++;
        if (sif.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_cycle2_valid: got %0b, expected 0", sif.out_valid);
        end
        cyc();
        vectors++;
        if (sif.out_valid !== 1'b1 || sif.out_data !== rom_word(16'h010)) begin
            miscompares++;
            $display("FAIL basic_cycle3_beat: got valid/data %0b/%0h, expected 1/%0h",
                     sif.out_valid, sif.out_data, rom_word(16'h010));
        end
        wait_done(20, n);
        vectors++;
        if (n !== 4) begin
            miscompares++;
            $display("FAIL basic_done_cycle: got done after %0d cycles past cycle 3, expected 4", n);
        end
        cyc();
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL basic_end: got done/busy/pending %0b/%0b/%0d, expected 0/0/0",
                     done, busy, exp_q.size());
        end
    endtask

    task automatic test_wrap();
        int n;
        sif.out_ready = 1'b1;
        do_start(10'h3FE, 4);
        wait_done(40, n);
        vectors++;
        if (n >= 40 || exp_q.size() != 0 || addr_q.size() != 0) begin
            miscompares++;
            $display("FAIL wrap_complete: got cycles %0d pending beats %0d reads %0d, expected <40/0/0",
                     n, exp_q.size(), addr_q.size());
        end
        cyc();
    endtask

    task automatic test_backpressure();
        int k;
        beats_seen    = 0;
        sif.out_ready = 1'b1;
        do_start(10'h055, 8);
        k = 0;
        while (!done && k < 200) begin
            sif.out_ready = (k % 3 == 0);
            cyc();
            k++;
        end
        sif.out_ready = 1'b1;
        vectors++;
        if (k >= 200 || beats_seen != 8 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL backpressure: got cycles %0d beats %0d pending %0d, expected <200/8/0",
                     k, beats_seen, exp_q.size());
        end
        cyc();
    endtask

    task automatic test_zero_len();
        beats_seen    = 0;
        sif.out_ready = 1'b1;
        do_start(10'h123, 0);
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0 || rom_en !== 1'b0 || sif.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_len_cycle1: got done/busy/en/valid %0b%0b%0b%0b, expected 1000",
                     done, busy, rom_en, sif.out_valid);
        end
        cyc();
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0 || rom_en !== 1'b0 || beats_seen != 0) begin
            miscompares++;
            $display("FAIL zero_len_cycle2: got done/busy/en %0b%0b%0b beats %0d, expected 000/0",
                     done, busy, rom_en, beats_seen);
        end
    endtask

    task automatic test_full();
        int n;
        beats_seen    = 0;
        sif.out_ready = 1'b1;
        do_start(10'h000, 1024);
        repeat (100) cyc();
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL full_busy: got %0b, expected 1", busy);
        end
        start = 1'b1; base_addr = 10'h200; length = 11'd5;
        cyc();
        start = 1'b0;
        wait_done(1200, n);
        vectors++;
        if (n >= 1200 || beats_seen != 1024 || exp_q.size() != 0 || addr_q.size() != 0) begin
            miscompares++;
            $display("FAIL full_complete: got cycles %0d beats %0d pending %0d, expected <1200/1024/0",
                     n, beats_seen, exp_q.size());
        end
        cyc();
    endtask

    task automatic test_reset_mid();
        int k;
        int n;
        beats_seen    = 0;
        sif.out_ready = 1'b1;
        do_start(10'h100, 10);
        k = 0;
        while (beats_seen < 3 && k < 20) begin
            cyc();
            k++;
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (k >= 20 || {busy, done, rom_en, rom_addr, sif.out_valid, sif.out_data, sif.out_last} !== '0) begin
            miscompares++;
            $display("FAIL mid_reset_outputs: got %0h after %0d cycles, expected 0",
                     {busy, done, rom_en, rom_addr, sif.out_valid, sif.out_data, sif.out_last}, k);
        end
        exp_q.delete();
        addr_q.delete();
        cyc(); cyc();
        rst = 1'b0;
        cyc();
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_no_done: got done/busy %0b/%0b, expected 0/0", done, busy);
        end
        beats_seen = 0;
        do_start(10'h020, 3);
        wait_done(40, n);
        vectors++;
        if (n >= 40 || beats_seen != 3 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL mid_reset_restart: got cycles %0d beats %0d pending %0d, expected <40/3/0",
                     n, beats_seen, exp_q.size());
        end
        cyc();
    endtask

    initial begin
        for (int a = 0; a < (1 << AW); a++) mem[a] = rom_word(a);
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero_len();
        test_full();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running at 200000, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
